// File: rtl/rect_plotter.sv
// Raster plotter: sweeps a w x h rectangle row-major from (x0,y0), emitting one pixel slot per
// clock to the framebuffer adapter, with solid-fill or sprite-ROM colour, clipping and abort.
module rect_plotter #(
    parameter int                  X_W         = 8,
    parameter int                  Y_W         = 7,
    parameter int                  SCREEN_W    = 160,
    parameter int                  SCREEN_H    = 120,
    parameter int                  COLOUR_W    = 3,
    parameter int                  ADDR_W      = 15,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                active,
    input  logic                abort,
    input  logic                mode,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] fill_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                writeEn,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLOT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [X_W-1:0]      x0_reg;
    logic [Y_W-1:0]      y0_reg;
    logic [X_W-1:0]      w_reg;
    logic [Y_W-1:0]      h_reg;
    logic                mode_reg;
    logic [COLOUR_W-1:0] fill_reg;

    logic [X_W-1:0]      cx_reg;
    logic [Y_W-1:0]      cy_reg;
    logic [ADDR_W-1:0]   rom_addr_reg;

    logic [X_W-1:0]      x_reg;
    logic [Y_W-1:0]      y_reg;
    logic [COLOUR_W-1:0] colour_reg;
    logic                we_reg;

    logic                launch;
    logic                empty;
    logic                last_col;
    logic                last_px;
    logic                emit;
    logic                busy_next;
    logic                done_next;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic                clip;
    logic                transp;

    assign launch   = (state_reg == S_IDLE) && start && active;
    assign empty    = (w_reg == '0) || (h_reg == '0);
    assign last_col = (cx_reg == w_reg - X_W'(1));
    assign last_px  = last_col && (cy_reg == h_reg - Y_W'(1));

    // One extra bit keeps off-screen sums from wrapping back onto the visible area.
    assign x_sum  = {1'b0, x0_reg} + {1'b0, cx_reg};
    assign y_sum  = {1'b0, y0_reg} + {1'b0, cy_reg};
    assign clip   = (x_sum >= (X_W+1)'(SCREEN_W)) || (y_sum >= (Y_W+1)'(SCREEN_H));
    assign transp = mode_reg && (rom_data == TRANSPARENT);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (launch) begin
                    state_next = S_PLOT;
                end
            end
            S_PLOT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (empty || last_px) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A zero-sized request still spends one PLOT cycle, but issues no pixel slot.
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        emit      = 1'b0;
        case (state_reg)
            S_PLOT: begin
                busy_next = 1'b1;
                emit      = !empty;
            end
            S_DONE: begin
                busy_next = 1'b1;
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            mode_reg     <= 1'b0;
            fill_reg     <= '0;
            cx_reg       <= '0;
            cy_reg       <= '0;
            rom_addr_reg <= '0;
        end else if (launch) begin
            x0_reg       <= x0;
            y0_reg       <= y0;
            w_reg        <= w;
            h_reg        <= h;
            mode_reg     <= mode;
            fill_reg     <= fill_colour;
            cx_reg       <= '0;
            cy_reg       <= '0;
            rom_addr_reg <= '0;
        end else if (emit) begin
            rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
            if (last_col) begin
                cx_reg <= '0;
                cy_reg <= cy_reg + Y_W'(1);
            end else begin
                cx_reg <= cx_reg + X_W'(1);
            end
        end
    end

    // Output stage trails the counters by one cycle; abort kills the slot being registered.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            we_reg     <= 1'b0;
        end else begin
            we_reg <= emit && !abort && !clip && !transp;
            if (emit) begin
                x_reg      <= x_sum[X_W-1:0];
                y_reg      <= y_sum[Y_W-1:0];
                colour_reg <= mode_reg ? rom_data : fill_reg;
            end
        end
    end

    assign x        = x_reg;
    assign y        = y_reg;
    assign colour   = colour_reg;
    assign writeEn  = we_reg;
    assign rom_addr = rom_addr_reg;
    assign busy     = busy_next;
    assign done     = done_next;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: fill, sprite/transparency, clipping, zero size, abort, reset.
module tb_rect_plotter;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        active = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  x0 = '0;
    logic [6:0]  y0 = '0;
    logic [7:0]  w = '0;
    logic [6:0]  h = '0;
    logic [2:0]  fill_colour = '0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic        done;

    logic [2:0] rom_mem [0:7];
    assign rom_data = rom_mem[rom_addr[2:0]];

    rect_plotter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .active      (active),
        .abort       (abort),
        .mode        (mode),
        .x0          (x0),
        .y0          (y0),
        .w           (w),
        .h           (h),
        .fill_colour (fill_colour),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEn     (writeEn),
        .busy        (busy),
        .done        (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } wr_t;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t wr_q[$];
    int  done_q[$];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // cyc read at the falling edge is the index of the rising edge that produced the value.
    always @(negedge CLOCK_50) begin
        if (writeEn) begin
            wr_q.push_back('{int'(x), int'(y), int'(colour), cyc});
            $display("t=%0d write (%0d,%0d) c%0d", cyc, x, y, colour);
        end
        if (done) $display("t=%0d done", cyc);
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic m, input int px, input int py, input int pw,
                          input int ph, input int pc, output int k);
        @(negedge CLOCK_50);
        wr_q.delete();
        done_q.delete();
        mode        = m;
        x0          = 8'(px);
        y0          = 7'(py);
        w           = 8'(pw);
        h           = 7'(ph);
        fill_colour = 3'(pc);
        start       = 1'b1;
        active      = 1'b1;
        @(posedge CLOCK_50);
        #1;
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
    endtask

    task automatic wait_writes(input int cnt, input int budget);
        int n;
        n = 0;
        while (wr_q.size() < cnt && n < budget) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
    endtask

    task automatic expect_write(input string tag, input int i, input int ex, input int ey,
                                input int ec, input int et);
        if (wr_q.size() > i) begin
            check({tag, "_x"}, wr_q[i].x, ex);
            check({tag, "_y"}, wr_q[i].y, ey);
            check({tag, "_c"}, wr_q[i].c, ec);
            check({tag, "_t"}, wr_q[i].t, et);
        end else begin
            check({tag, "_present"}, wr_q.size(), i + 1);
        end
    endtask

    initial begin
        int k;
        int bad;

        rom_mem[0] = 3'd1; rom_mem[1] = 3'd0; rom_mem[2] = 3'd2; rom_mem[3] = 3'd0;
        rom_mem[4] = 3'd3; rom_mem[5] = 3'd3; rom_mem[6] = 3'd0; rom_mem[7] = 3'd4;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_we", int'(writeEn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_xy", int'({x, y}), 0);
        check("rst_rom", int'(rom_addr), 0);
        reset = 1'b0;

        // start ignored while inactive
        @(negedge CLOCK_50);
        w = 8'd4; h = 7'd4; start = 1'b1; active = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("inactive_busy", int'(busy), 0);
        start = 1'b0;

        // 1: full-screen fill
        launch(1'b0, 0, 0, 160, 120, 5, k);
        check("t1_busy", int'(busy), 1);
        wait_done(20000);
        check("t1_done_cnt", done_q.size(), 1);
        check("t1_writes", wr_q.size(), 19200);
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++) begin
            if (wr_q[i].x != i % 160 || wr_q[i].y != i / 160 || wr_q[i].c != 5
                || wr_q[i].t != k + 1 + i) bad++;
        end
        check("t1_raster", bad, 0);
        if (done_q.size() > 0) check("t1_done_t", done_q[0], k + 19200);
        @(negedge CLOCK_50);
        #1;
        check("t1_idle", int'(busy), 0);

        // 2: sprite with transparency
        launch(1'b1, 10, 5, 4, 2, 7, k);
        wait_done(50);
        check("t2_writes", wr_q.size(), 5);
        expect_write("t2_w0", 0, 10, 5, 1, k + 1);
        expect_write("t2_w1", 1, 12, 5, 2, k + 3);
        expect_write("t2_w2", 2, 10, 6, 3, k + 5);
        expect_write("t2_w3", 3, 11, 6, 3, k + 6);
        expect_write("t2_w4", 4, 13, 6, 4, k + 8);
        check("t2_rom_end", int'(rom_addr), 8);
        if (done_q.size() > 0) check("t2_done_t", done_q[0], k + 8);
        else check("t2_done_cnt", done_q.size(), 1);

        // 3: clipping at the bottom-right corner
        launch(1'b0, 158, 118, 4, 4, 6, k);
        wait_done(50);
        check("t3_writes", wr_q.size(), 4);
        expect_write("t3_w0", 0, 158, 118, 6, k + 1);
        expect_write("t3_w1", 1, 159, 118, 6, k + 2);
        expect_write("t3_w2", 2, 158, 119, 6, k + 5);
        expect_write("t3_w3", 3, 159, 119, 6, k + 6);
        if (done_q.size() > 0) check("t3_done_t", done_q[0], k + 16);
        else check("t3_done_cnt", done_q.size(), 1);

        // 4: zero width
        launch(1'b0, 3, 3, 0, 5, 1, k);
        check("t4_busy0", int'(busy), 1);
        check("t4_done0", int'(done), 0);
        @(posedge CLOCK_50);
        #1;
        check("t4_busy1", int'(busy), 1);
        check("t4_done1", int'(done), 1);
        @(posedge CLOCK_50);
        #1;
        check("t4_busy2", int'(busy), 0);
        check("t4_writes", wr_q.size(), 0);
        check("t4_done_cnt", done_q.size(), 1);

        // 5: abort together with a re-start after 10 strobes
        launch(1'b0, 20, 20, 8, 8, 2, k);
        wait_writes(10, 40);
        check("t5_pre", wr_q.size(), 10);
        start = 1'b1; abort = 1'b1; x0 = 8'd99;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0; abort = 1'b0;
        check("t5_idle", int'(busy), 0);
        repeat (20) @(posedge CLOCK_50);
        #1;
        check("t5_writes", wr_q.size(), 10);
        check("t5_no_done", done_q.size(), 0);
        expect_write("t5_last", 9, 21, 21, 2, k + 10);

        // 6: reset mid-plot, then a fresh request
        launch(1'b0, 0, 0, 10, 10, 3, k);
        wait_writes(5, 40);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check("t6_we", int'(writeEn), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_outs", int'({x, y, colour, rom_addr, done}), 0);
        launch(1'b0, 1, 1, 2, 2, 7, k);
        wait_done(20);
        check("t6_writes", wr_q.size(), 4);
        expect_write("t6_w3", 3, 2, 2, 7, k + 4);
        if (done_q.size() > 0) check("t6_done_t", done_q[0], k + 4);
        else check("t6_done_cnt", done_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
